// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks in-flight writers per architectural register and
// derives the ID-stage stall and per-operand forwarding hints.
module reg_scoreboard #(
  parameter int unsigned NREG  = 32,
  parameter int unsigned LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic             use_rs1_d,
  input  logic             use_rs2_d,
  input  logic             issue_valid,
  input  logic             issue_regwrite,
  input  logic [4:0]       issue_rd,
  input  logic [LAT_W-1:0] issue_lat,
  input  logic             flush_d,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  output logic             stall_d,
  output logic             rs1_fwd_d,
  output logic             rs2_fwd_d,
  output logic [NREG-1:0]  busy_o
);

  logic [NREG-1:0]  busy_q, busy_d;
  logic [LAT_W-1:0] cnt_q [NREG];
  logic [LAT_W-1:0] cnt_d [NREG];

  logic rs1_pend, rs2_pend;
  logic haz1, haz2, waw;
  logic wb_hit, issue_ok;

  // Source hazards, WAW check and the stall decision, all from registered state.
  always_comb begin
    rs1_pend  = use_rs1_d && (rs1_d != 5'd0) && busy_q[rs1_d];
    rs2_pend  = use_rs2_d && (rs2_d != 5'd0) && busy_q[rs2_d];
    haz1      = rs1_pend && (cnt_q[rs1_d] != '0);
    haz2      = rs2_pend && (cnt_q[rs2_d] != '0);
    rs1_fwd_d = rs1_pend && (cnt_q[rs1_d] == '0);
    rs2_fwd_d = rs2_pend && (cnt_q[rs2_d] == '0);
    wb_hit    = wb_valid && (wb_rd != 5'd0);
    // An older writer committing this very cycle frees the slot for the new one.
    waw       = issue_valid && issue_regwrite && (issue_rd != 5'd0) && busy_q[issue_rd] &&
                !(wb_valid && (wb_rd == issue_rd));
    stall_d   = issue_valid && !flush_d && (haz1 || haz2 || waw);
    issue_ok  = issue_valid && issue_regwrite && (issue_rd != 5'd0) && !stall_d && !flush_d;
  end

  // Next state: countdown, then writeback clear, then issue (issue wins on same rd).
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < int'(NREG); i++) begin
      cnt_d[i] = cnt_q[i];
      if (busy_q[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - LAT_W'(1);
      end
    end
    if (wb_hit) begin
      busy_d[wb_rd] = 1'b0;
      cnt_d[wb_rd]  = '0;
    end
    if (issue_ok) begin
      busy_d[issue_rd] = 1'b1;
      cnt_d[issue_rd]  = issue_lat;
    end
    busy_d[0] = 1'b0;
    cnt_d[0]  = '0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      for (int i = 0; i < int'(NREG); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      for (int i = 0; i < int'(NREG); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign busy_o = busy_q;

endmodule
